// File: rtl/systolic_feeder_4x4.sv
// systolic_feeder_4x4: buffers a 4x4 A/B tile and feeds it diagonally skewed into a 4x4 systolic array.
// Optional FEEDER_PERF_CNT_EN adds tile/stall performance counters.
module systolic_feeder_4x4 #(
  parameter int data_width   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*data_width-1:0] a_col_flat,
  input  logic [4*data_width-1:0] b_row_flat,
  output logic [4*data_width-1:0] a_in_flat,
  output logic [4*data_width-1:0] b_in_flat,
  output logic                    arr_en,
  output logic                    acc_clr,
  output logic                    busy,
  output logic                    tile_done,
  output logic [15:0]             tile_cnt,
  output logic [15:0]             stall_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [data_width-1:0] a_buf [4][4];
  logic [data_width-1:0] b_buf [4][4];
  logic xfer;
  logic [1:0] slot;
  assign in_ready  = state == IDLE || state == LOAD;
  assign xfer      = in_valid && in_ready;
  assign slot      = state == IDLE ? 2'd0 : cnt[1:0];
  assign arr_en    = state == STREAM || state == DRAIN;
  assign acc_clr   = state == CLEAR;
  assign busy      = state != IDLE;
  assign tile_done = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = xfer ? LOAD : IDLE;
      LOAD:    state_nxt = (xfer && cnt == 4'd3) ? CLEAR : LOAD;
      CLEAR:   state_nxt = STREAM;
      STREAM:  state_nxt = cnt == 4'd6 ? DRAIN : STREAM;
      DRAIN:   state_nxt = cnt == 4'(DRAIN_CYCLES - 1) ? DONE : DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // One counter serves as beat index in LOAD, skew step in STREAM and drain timer in DRAIN
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (state != state_nxt) cnt <= state_nxt == LOAD ? 4'd1 : 4'd0;
    else cnt <= state == IDLE ? 4'd0 : state == LOAD ? cnt + 4'(xfer) : cnt + 4'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_buf[i][j] <= '0;
          b_buf[i][j] <= '0;
        end
    end else if (xfer) begin
      for (int i = 0; i < 4; i++) begin
        a_buf[i][slot] <= a_col_flat[i*data_width +: data_width];
        b_buf[slot][i] <= b_row_flat[i*data_width +: data_width];
      end
    end
  // Lane n lags by n cycles; an out-of-window index wraps to >= 4 and yields zero
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [3:0] d;
    assign d = cnt - 4'(n);
    assign a_in_flat[n*data_width +: data_width] = (state == STREAM && d < 4'd4) ? a_buf[n][d[1:0]] : '0;
    assign b_in_flat[n*data_width +: data_width] = (state == STREAM && d < 4'd4) ? b_buf[d[1:0]][n] : '0;
  end
`ifdef FEEDER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tile_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      tile_cnt  <= tile_cnt + 16'(state == DONE);
      stall_cnt <= (in_valid && !in_ready && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
`else
  assign tile_cnt  = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// tb_systolic_feeder_4x4: randomized tiles checked against a matrix-level model of the skewed feed.
module tb_systolic_feeder_4x4;
  localparam int W  = 8;
  localparam int DC = 4;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [4*W-1:0] a_col_flat = '0, b_row_flat = '0;
  logic [4*W-1:0] a_in_flat, b_in_flat;
  logic in_ready, arr_en, acc_clr, busy, tile_done;
  logic [15:0] tile_cnt, stall_cnt;
  int checks = 0, failures = 0, exp_stall = 0, exp_tiles = 0;
  bit exp_rdy = 1;
  int A[4][4], B[4][4];

  systolic_feeder_4x4 #(.data_width(W), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_col_flat(a_col_flat), .b_row_flat(b_row_flat),
    .a_in_flat(a_in_flat), .b_in_flat(b_in_flat),
    .arr_en(arr_en), .acc_clr(acc_clr), .busy(busy), .tile_done(tile_done),
    .tile_cnt(tile_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (in_valid && !exp_rdy) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*W-1:0] exp_a(input int s);
    logic [4*W-1:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (s - i >= 0 && s - i <= 3) r[i*W +: W] = W'(A[i][s-i]);
    return r;
  endfunction

  function automatic logic [4*W-1:0] exp_b(input int s);
    logic [4*W-1:0] r = '0;
    for (int j = 0; j < 4; j++)
      if (s - j >= 0 && s - j <= 3) r[j*W +: W] = W'(B[s-j][j]);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {in_ready, busy, arr_en, acc_clr, tile_done}, 5'b10000);
    check({tag, "_data"}, {a_in_flat, b_in_flat}, '0);
  endtask

  task automatic check_perf(input string tag);
`ifdef FEEDER_PERF_CNT_EN
    check({tag, "_tile_cnt"}, tile_cnt, exp_tiles);
    check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`else
    check({tag, "_cnt_off"}, {tile_cnt, stall_cnt}, '0);
`endif
  endtask

  task automatic rand_tile();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = $urandom_range(0, 255);
        B[i][j] = $urandom_range(0, 255);
      end
  endtask

  task automatic load_tile(input int gap, input bit hold);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 0;
        a_col_flat = $urandom;
        b_row_flat = $urandom;
        exp_rdy = 1;
        tick();
      end
      in_valid = 1;
      for (int i = 0; i < 4; i++) begin
        a_col_flat[i*W +: W] = W'(A[i][k]);
        b_row_flat[i*W +: W] = W'(B[k][i]);
      end
      check("beat_ready", in_ready, 1'b1);
      exp_rdy = 1;
      tick();
    end
    in_valid = hold;
    a_col_flat = $urandom;
    b_row_flat = $urandom;
    exp_rdy = 0;
  endtask

  task automatic stream_tile(input bit hold);
    check("clear_ctl", {acc_clr, arr_en, busy, in_ready, tile_done}, 5'b10100);
    check("clear_data", {a_in_flat, b_in_flat}, '0);
    for (int s = 0; s < 7; s++) begin
      tick();
      if (hold) begin
        a_col_flat = $urandom;
        b_row_flat = $urandom;
      end
      check("stream_en", {arr_en, acc_clr, in_ready}, 3'b100);
      check($sformatf("stream_a_s%0d", s), a_in_flat, exp_a(s));
      check($sformatf("stream_b_s%0d", s), b_in_flat, exp_b(s));
    end
    for (int d = 0; d < DC; d++) begin
      tick();
      check("drain_ctl", {arr_en, tile_done, acc_clr}, 3'b100);
      check("drain_data", {a_in_flat, b_in_flat}, '0);
    end
    tick();
    check("done_ctl", {tile_done, arr_en, busy, in_ready}, 4'b1010);
    tick();
    exp_rdy = 1;
    exp_tiles++;
    check("post_done", {tile_done, busy, in_ready, arr_en}, 4'b0010);
  endtask

  initial begin
    #12;
    check_idle("reset");
    check_perf("reset");
    rst = 1;
    tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 4*i + j + 1;
        B[i][j] = 4*i + j + 17;
      end
    check("fixed_s3_a", exp_a(3), {8'd13, 8'd10, 8'd7, 8'd4});
    check("fixed_s3_b", exp_b(3), {8'd20, 8'd23, 8'd26, 8'd29});
    load_tile(0, 1);
    stream_tile(1);
    rand_tile();
    load_tile(0, 0);
    stream_tile(0);
    check_perf("b2b");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 4*i + j + 1;
        B[i][j] = 4*i + j + 17;
      end
    load_tile(1, 0);
    stream_tile(0);
    for (int t = 0; t < 6; t++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      rand_tile();
      load_tile($urandom_range(0, 2), h);
      stream_tile(h);
    end
    in_valid = 0;
    tick();
    check_perf("random");
    rand_tile();
    load_tile(0, 0);
    tick();
    tick();
    tick();
    check("pre_rst_stream", arr_en, 1'b1);
    #2;
    rst = 0;
    #1;
    exp_stall = 0;
    exp_tiles = 0;
    check_idle("async_rst");
    check_perf("async_rst");
    #1;
    rst = 1;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("after_rst_quiet", {tile_done, busy, arr_en}, 3'b000);
    end
    rand_tile();
    load_tile(2, 0);
    stream_tile(0);
    check_perf("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_feeder_4x4.md
Name: systolic_feeder_4x4

Overview:
Input-skew stage sitting directly upstream of systolic_array_4x4. Accepts one 4x4 tile of A and B as four k-beats over a valid/ready handshake and buffers it. It then drives the array's a_in_flat/b_in_flat with diagonally staggered lanes (lane i delayed by i cycles), generates the array enable, and pulses done once the tile has drained through the array.

Parameters:
data_width, 8, element width of A and B; lane width on all flat buses
DRAIN_CYCLES, 4, zero-data cycles with arr_en high after the last stream beat (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  beat valid
in_ready  output  1  feeder can accept a beat
a_col_flat  input  4*data_width  column k of A: lane i = A[i][k]
b_row_flat  input  4*data_width  row k of B: lane j = B[k][j]
a_in_flat  output  4*data_width  to array a_in_flat
b_in_flat  output  4*data_width  to array b_in_flat
arr_en  output  1  to array en
acc_clr  output  1  one-cycle accumulator clear request to array
busy  output  1  state != IDLE
tile_done  output  1  one-cycle pulse, tile fully drained
tile_cnt  output  16  tiles completed (see optional feature)
stall_cnt  output  16  in_valid && !in_ready cycles (see optional feature)

Behaviour:
- Lane packing: lane n at bits [n*data_width +: data_width], lane 0 = LSB.
- Reset (rst low, async): state IDLE; buffer, beat counter and stream counter zero; all outputs 0 except in_ready = 1.
- Handshake: beat transfers on rising edge with in_valid && in_ready. in_ready = 1 in IDLE and LOAD only. Data is sampled only on transfer.
- FSM (all outputs registered/Moore):
  - IDLE: on transfer, store beat into slot k=0 and go to LOAD with k=1.
  - LOAD: on each transfer, store into slot k. After slot 3 is stored, go to CLEAR. No transfer means hold.
  - CLEAR: 1 cycle. acc_clr = 1, arr_en = 0, data 0. Then STREAM with s = 0.
  - STREAM: s = 0..6, one cycle each, arr_en = 1.
    - a_in_flat lane i = A[i][s-i] if 0 <= s-i <= 3, else 0.
    - b_in_flat lane j = B[s-j][j] if 0 <= s-j <= 3, else 0.
    - After s = 6, go to DRAIN.
  - DRAIN: DRAIN_CYCLES cycles, arr_en = 1, data 0. Then DONE.
  - DONE: 1 cycle, tile_done = 1, arr_en = 0. Then IDLE.
- Latency: CLEAR begins the cycle after the 4th beat is accepted. tile_done rises 1 + 7 + DRAIN_CYCLES cycles after CLEAR begins (12 at default).
- Back-to-back tiles: a beat is accepted in IDLE the cycle after DONE. The minimum tile period is 4 + 1 + 7 + DRAIN_CYCLES + 1 cycles.
- in_valid while not ready: ignored, with no buffer corruption. Buffer contents persist until overwritten.
- Reset mid-operation: immediate return to IDLE with reset values. The partial tile is discarded and no tile_done is produced.
- Outside STREAM, a_in_flat and b_in_flat are 0.

Optional Feature:
Macro FEEDER_PERF_CNT_EN.
- Defined:
  - tile_cnt increments on each DONE cycle and wraps at 16'hFFFF -> 0.
  - stall_cnt increments each cycle with in_valid && !in_ready and saturates at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: counter logic is absent and tile_cnt = stall_cnt = 0 constantly. Functional behaviour is otherwise identical.

Test Plan:
- Reset -> in_ready=1, busy=0, arr_en=0, acc_clr=0, tile_done=0, a_in_flat=b_in_flat=0. Assert rst low mid-STREAM -> same values asynchronously.
- Tile A[i][k]=4i+k+1, B[k][j]=4k+j+17, 4 beats with in_valid held high -> CLEAR: acc_clr=1. Expected stream, lanes listed lane3..lane0:
  - s=0: a={0,0,0,1}, b={0,0,0,17}
  - s=3: a={13,10,7,4}, b={20,23,26,29}
  - s=6: a={16,0,0,0}, b={32,0,0,0}
- Same tile -> arr_en high for exactly 11 cycles; tile_done pulses once, 12 cycles after CLEAR; busy falls with IDLE.
- Beats with in_valid gapped (1 idle cycle between beats) -> stream identical to the previous test; no extra beats captured.
- in_valid held high through a whole tile plus a second tile -> second tile's beat 0 accepted the cycle after DONE. With FEEDER_PERF_CNT_EN: stall_cnt=13 and tile_cnt=2 after the second tile.
- DRAIN_CYCLES=1 build -> tile_done 9 cycles after CLEAR; arr_en high 8 cycles.
